// File: rtl/rvfi_retire_monitor.sv
// rvfi_retire_monitor: numbers retiring lanes and emits registered commit strobes.
// It also raises sticky flags for a self-loop halt, a retirement watchdog timeout and non-contiguous lanes.
module rvfi_retire_monitor #(
    parameter int NRET        = 2,
    parameter int XLEN        = 32,
    parameter int ORDER_W     = 64,
    parameter int HALT_REPEAT = 2,
    parameter int WATCHDOG    = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NRET-1:0]         ret_valid,
    input  logic [NRET*XLEN-1:0]    ret_pc_rdata,
    input  logic [NRET*XLEN-1:0]    ret_pc_wdata,
    output logic [NRET-1:0]         commit,
    output logic [NRET*ORDER_W-1:0] order,
    output logic                    halt,
    output logic                    timeout,
    output logic                    lane_gap_err,
    output logic [ORDER_W-1:0]      retired_total
);
    localparam int RUN_W = $clog2(HALT_REPEAT + 1) + 1;
    localparam int WD_W  = $clog2(WATCHDOG + 1) + 1;

    logic [RUN_W-1:0]        run_q, run_d;
    logic [XLEN-1:0]         last_pc_q, last_pc_d;
    logic [WD_W-1:0]         wd_q;
    logic [NRET-1:0]         elig;
    logic [NRET*ORDER_W-1:0] order_d;
    logic [ORDER_W-1:0]      cnt;
    logic                    hit, gap, seen_idle;

    // Lanes are walked oldest first so a halt on lane k masks every younger lane.
    always_comb begin
        run_d = run_q;
        last_pc_d = last_pc_q;
        hit = 1'b0;
        gap = 1'b0;
        seen_idle = 1'b0;
        cnt = '0;
        elig = '0;
        order_d = '0;
        for (int i = 0; i < NRET; i++) begin
            gap = gap | (ret_valid[i] & seen_idle);
            seen_idle = seen_idle | ~ret_valid[i];
            elig[i] = ret_valid[i] & ~halt & ~hit;
            order_d[i*ORDER_W +: ORDER_W] = retired_total + cnt;
            if (elig[i]) begin
                cnt = cnt + ORDER_W'(1);
                if (ret_pc_wdata[i*XLEN +: XLEN] == ret_pc_rdata[i*XLEN +: XLEN]) begin
                    run_d = (ret_pc_rdata[i*XLEN +: XLEN] == last_pc_d) ? run_d + RUN_W'(1) : RUN_W'(1);
                    last_pc_d = ret_pc_rdata[i*XLEN +: XLEN];
                end else begin
                    run_d = '0;
                end
                hit = (run_d == RUN_W'(HALT_REPEAT));
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            commit <= '0;
            order <= '0;
            halt <= 1'b0;
            timeout <= 1'b0;
            lane_gap_err <= 1'b0;
            retired_total <= '0;
            run_q <= '0;
            last_pc_q <= '0;
            wd_q <= '0;
        end else if (!halt) begin
            commit <= elig;
            order <= order_d;
            retired_total <= retired_total + cnt;
            run_q <= run_d;
            last_pc_q <= last_pc_d;
            halt <= hit;
            lane_gap_err <= lane_gap_err | gap;
            if (cnt != '0) begin
                wd_q <= '0;
            end else if (WATCHDOG != 0 && wd_q != WD_W'(WATCHDOG)) begin
                wd_q <= wd_q + WD_W'(1);
                timeout <= timeout | (wd_q == WD_W'(WATCHDOG - 1));
            end
        end else begin
            commit <= '0;
        end
    end
endmodule

// File: tb/tb_rvfi_retire_monitor.sv
// tb_rvfi_retire_monitor: directed and randomized retirement streams against a scoreboarded lane model.
module tb_rvfi_retire_monitor;
    localparam int HR = 2;
    localparam int WD = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   ret_valid = '0;
    logic [63:0]  ret_pc_rdata = '0;
    logic [63:0]  ret_pc_wdata = '0;
    logic [1:0]   commit;
    logic [127:0] order;
    logic         halt, timeout, lane_gap_err;
    logic [63:0]  retired_total;

    always #5 clk = ~clk;

    rvfi_retire_monitor #(
        .NRET(2), .XLEN(32), .ORDER_W(64), .HALT_REPEAT(HR), .WATCHDOG(WD)
    ) dut (
        .clk(clk), .rst(rst), .ret_valid(ret_valid),
        .ret_pc_rdata(ret_pc_rdata), .ret_pc_wdata(ret_pc_wdata),
        .commit(commit), .order(order), .halt(halt), .timeout(timeout),
        .lane_gap_err(lane_gap_err), .retired_total(retired_total)
    );

    typedef struct {
        logic [1:0]  commit;
        logic [63:0] o0, o1, total;
        logic        halt, timeout, gap;
    } exp_t;

    exp_t q[$];
    int n_chk = 0;
    int n_pass = 0;

    logic [63:0] m_total;
    logic [31:0] m_lpc;
    int          m_run, m_idle;
    bit          m_halt, m_to, m_gap;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Drive one cycle of retirements and predict what the monitor must report for it.
    task automatic step(input logic [1:0] v, input logic [31:0] r0, input logic [31:0] w0,
                        input logic [31:0] r1, input logic [31:0] w1);
        exp_t e;
        logic [31:0] r[2];
        logic [31:0] w[2];
        bit stop;
        r[0] = r0; r[1] = r1; w[0] = w0; w[1] = w1;
        e.commit = '0; e.o0 = '0; e.o1 = '0;
        stop = m_halt;
        if (!m_halt && v == 2'b10) m_gap = 1;
        for (int i = 0; i < 2; i++) begin
            if (v[i] && !stop) begin
                e.commit[i] = 1'b1;
                if (i == 0) e.o0 = m_total; else e.o1 = m_total;
                m_total = m_total + 1;
                if (r[i] == w[i]) begin
                    m_run = (r[i] == m_lpc) ? m_run + 1 : 1;
                    m_lpc = r[i];
                end else begin
                    m_run = 0;
                end
                stop = (m_run == HR);
            end
        end
        if (!m_halt) begin
            if (e.commit != 0) m_idle = 0;
            else if (m_idle < WD) begin
                m_idle++;
                if (m_idle == WD) m_to = 1;
            end
        end
        m_halt = stop;
        e.halt = m_halt; e.timeout = m_to; e.gap = m_gap; e.total = m_total;
        ret_valid = v;
        ret_pc_rdata = {r1, r0};
        ret_pc_wdata = {w1, w0};
        q.push_back(e);
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        ret_valid = '0;
        q.delete();
        #1;
        chk("rst_commit", 64'(commit), 0);
        chk("rst_order", order[63:0] | order[127:64], 0);
        chk("rst_halt", 64'(halt), 0);
        chk("rst_timeout", 64'(timeout), 0);
        chk("rst_gap", 64'(lane_gap_err), 0);
        chk("rst_total", retired_total, 0);
        m_total = 0; m_lpc = 0; m_run = 0; m_idle = 0;
        m_halt = 0; m_to = 0; m_gap = 0;
        @(negedge clk); #2;
        rst = 1'b1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("commit", 64'(commit), 64'(e.commit));
                chk("halt", 64'(halt), 64'(e.halt));
                chk("timeout", 64'(timeout), 64'(e.timeout));
                chk("lane_gap_err", 64'(lane_gap_err), 64'(e.gap));
                chk("retired_total", retired_total, e.total);
                if (e.commit[0]) chk("order0", order[63:0], e.o0);
                if (e.commit[1]) chk("order1", order[127:64], e.o1);
            end
        end
    end

    initial begin
        logic [1:0]  v;
        logic [31:0] r0, r1, w0, w1;
        @(negedge clk); #1;

        do_reset();
        step(2'b11, 32'h100, 32'h104, 32'h104, 32'h108);
        step(2'b11, 32'h108, 32'h10c, 32'h10c, 32'h110);
        step(2'b11, 32'h110, 32'h114, 32'h114, 32'h118);
        chk("t1_order0", order[63:0], 4);
        chk("t1_order1", order[127:64], 5);
        chk("t1_total", retired_total, 6);

        do_reset();
        step(2'b01, 32'h60, 32'h60, 32'h0, 32'h0);
        chk("t2_no_halt_yet", 64'(halt), 0);
        step(2'b01, 32'h60, 32'h60, 32'h0, 32'h0);
        chk("t2_halt", 64'(halt), 1);
        chk("t2_last_order", order[63:0], 1);
        step(2'b11, 32'h200, 32'h204, 32'h204, 32'h208);
        chk("t2_frozen_commit", 64'(commit), 0);
        chk("t2_frozen_total", retired_total, 2);

        do_reset();
        step(2'b11, 32'h80, 32'h80, 32'h80, 32'h80);
        chk("t3_commit", 64'(commit), 3);
        chk("t3_halt", 64'(halt), 1);

        do_reset();
        step(2'b01, 32'h40, 32'h40, 32'h0, 32'h0);
        step(2'b01, 32'h44, 32'h44, 32'h0, 32'h0);
        chk("t4_no_halt", 64'(halt), 0);
        step(2'b01, 32'h44, 32'h44, 32'h0, 32'h0);
        chk("t4_halt", 64'(halt), 1);

        do_reset();
        for (int i = 0; i < 3; i++) step(2'b00, 0, 0, 0, 0);
        chk("t5_pre_timeout", 64'(timeout), 0);
        step(2'b00, 0, 0, 0, 0);
        chk("t5_timeout", 64'(timeout), 1);
        step(2'b01, 32'h300, 32'h304, 0, 0);
        chk("t5_sticky", 64'(timeout), 1);

        do_reset();
        for (int i = 0; i < 3; i++) step(2'b00, 0, 0, 0, 0);
        step(2'b01, 32'h300, 32'h304, 0, 0);
        chk("t5b_no_timeout", 64'(timeout), 0);

        do_reset();
        step(2'b11, 32'h400, 32'h404, 32'h404, 32'h408);
        step(2'b10, 32'h0, 32'h0, 32'h408, 32'h40c);
        chk("t6_gap", 64'(lane_gap_err), 1);
        chk("t6_order1", order[127:64], 2);
        step(2'b01, 32'h40c, 32'h410, 0, 0);
        chk("t6_order0", order[63:0], 3);

        for (int s = 0; s < 10; s++) begin
            do_reset();
            for (int c = 0; c < 40; c++) begin
                v = ($urandom_range(0, (s % 2 == 1) ? 1 : 4) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
                r0 = 32'h40 + 32'($urandom_range(0, 3)) * 4;
                r1 = 32'h40 + 32'($urandom_range(0, 3)) * 4;
                w0 = ($urandom_range(0, 2) == 0) ? r0 : r0 + 4;
                w1 = ($urandom_range(0, 2) == 0) ? r1 : r1 + 4;
                step(v, r0, w0, r1, w1);
            end
        end

        do_reset();
        chk("queue_drained", 64'(q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
